// File: rtl/regfile_dump.sv
// regfile_dump: walks every architectural register through one read port and streams each value as an indexed valid/ready beat.
module regfile_dump #(
  parameter int WIDTH     = 32,
  parameter int REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dump_req_i,
  input  logic [WIDTH-1:0]     rd_data_i,
  input  logic                 out_ready_i,
  output logic [REG_WIDTH-1:0] rd_addr_o,
  output logic                 cpu_stall_o,
  output logic                 dump_busy_o,
  output logic                 dump_done_o,
  output logic                 out_valid_o,
  output logic [REG_WIDTH-1:0] out_idx_o,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_last_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [REG_WIDTH-1:0] LAST_IDX = '1;
  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] rd_idx_q, rd_idx_d, idx_q, idx_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d, last_q, last_d;
  logic                 load, accept;
  assign load   = (state_q == RUN) && (!valid_q || out_ready_i);
  assign accept = valid_q && out_ready_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = dump_req_i ? RUN : IDLE;
      RUN:     state_d = (load && rd_idx_q == LAST_IDX) ? DRAIN : RUN;
      DRAIN:   state_d = accept ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_addr_o   = (state_q == RUN) ? rd_idx_q : '0;
    dump_busy_o = (state_q == RUN) || (state_q == DRAIN);
    cpu_stall_o = dump_busy_o;
    dump_done_o = (state_q == DONE);
  end
  // x0 is hardwired to zero regardless of what the read port returns
  always_comb begin
    rd_idx_d = (state_q == IDLE && dump_req_i) ? '0
             : (load && rd_idx_q != LAST_IDX) ? rd_idx_q + 1'b1 : rd_idx_q;
    valid_d  = load ? 1'b1 : (accept ? 1'b0 : valid_q);
    data_d   = load ? ((rd_idx_q == '0) ? '0 : rd_data_i) : data_q;
    idx_d    = load ? rd_idx_q : idx_q;
    last_d   = load ? (rd_idx_q == LAST_IDX) : last_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      rd_idx_q <= rd_idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: drives snapshots against a stall-aware regfile and checks the beat stream against an expected register image.
module tb_regfile_dump;
  localparam int W = 32;
  localparam int R = 5;
  localparam int N = 1 << R;
  logic clk = 0, rst = 1;
  logic dump_req_i = 0, out_ready_i = 0;
  logic [W-1:0] rd_data_i;
  logic [R-1:0] rd_addr_o, out_idx_o;
  logic cpu_stall_o, dump_busy_o, dump_done_o, out_valid_o, out_last_o;
  logic [W-1:0] out_data_o;
  logic we = 0;
  logic [R-1:0] waddr = 0;
  logic [W-1:0] wdata = 0;
  logic [W-1:0] rf [N];
  logic [W-1:0] mem [N];
  int total = 0, passed = 0;

  regfile_dump #(.WIDTH(W), .REG_WIDTH(R)) dut (
    .clk(clk), .rst(rst), .dump_req_i(dump_req_i), .rd_data_i(rd_data_i),
    .out_ready_i(out_ready_i), .rd_addr_o(rd_addr_o), .cpu_stall_o(cpu_stall_o),
    .dump_busy_o(dump_busy_o), .dump_done_o(dump_done_o), .out_valid_o(out_valid_o),
    .out_idx_o(out_idx_o), .out_data_o(out_data_o), .out_last_o(out_last_o));

  always #5 clk = ~clk;
  assign rd_data_i = rf[rd_addr_o];
  // the core's write port is frozen while the dump engine stalls it
  always @(posedge clk) if (we && !cpu_stall_o) rf[waddr] <= wdata;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  typedef struct {
    int hold;
    bit rnd;
    bit inj;
    bit wr;
    int exp_done;
  } vec_t;

  task automatic run_dump(input vec_t v);
    logic [W-1:0] exp_d [N];
    int c, last_c, first_c, beats, dones;
    logic pv, pr, pl, busy_exp;
    logic [R-1:0] pi;
    logic [W-1:0] pd;
    if (v.wr) mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) exp_d[i] = (i == 0) ? '0 : mem[i];
    @(posedge clk); #1;
    dump_req_i = 1;
    out_ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (v.wr) begin we = 1; waddr = 5; wdata = 32'hDEADBEEF; end
    last_c = -1; first_c = -1; beats = 0; dones = 0;
    pv = 0; pr = 0; pl = 0; pi = 0; pd = 0;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      busy_exp = (c >= 1) && (last_c < 0);
      check("busy", dump_busy_o, busy_exp);
      check("stall", cpu_stall_o, busy_exp);
      check("done", dump_done_o, last_c >= 0 && c == last_c + 1);
      if (dump_done_o) dones++;
      if (c == 1) check("addr_cycle1", rd_addr_o, 0);
      if (v.hold > 0 && c >= 2 && c < 2 + v.hold) check("hold_rd_addr", rd_addr_o, 1);
      if (pv && !pr) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_idx", out_idx_o, pi);
        check("hold_data", out_data_o, pd);
        check("hold_last", out_last_o, pl);
      end
      if (out_valid_o && first_c < 0) begin
        first_c = c;
        check("first_beat_cycle", c, 2);
      end
      if (out_valid_o && out_ready_i && beats < N) begin
        check("beat_idx", out_idx_o, beats);
        check("beat_data", out_data_o, exp_d[beats]);
        check("beat_last", out_last_o, beats == N - 1);
        if (beats == N - 1) last_c = c;
        beats++;
      end
      pv = out_valid_o; pr = out_ready_i; pl = out_last_o; pi = out_idx_o; pd = out_data_o;
      if (last_c >= 0 && c == last_c + 2) break;
      @(posedge clk); #1;
      dump_req_i = v.inj && (c + 1 == 10 || (last_c >= 0 && c + 1 == last_c + 1));
      we = 0;
      if (v.wr && c + 1 == 5) begin we = 1; waddr = 7; wdata = 32'h12345678; end
      out_ready_i = v.rnd ? 1'($urandom_range(0, 1)) : !(c + 1 >= 2 && c + 1 < 2 + v.hold);
    end
    check("completed", last_c >= 0, 1);
    check("beat_count", beats, N);
    check("done_pulses", dones, 1);
    if (v.exp_done >= 0) check("done_cycle", last_c + 1, v.exp_done);
    dump_req_i = 0;
    we = 0;
  endtask

  vec_t vecs [5];
  int found;

  initial begin
    for (int i = 0; i < N; i++) begin
      we = 1; waddr = R'(i); wdata = 32'hA5A50000 + i;
      mem[i] = 32'hA5A50000 + i;
      @(posedge clk); #1;
    end
    we = 0;
    @(negedge clk);
    check("rst_valid", out_valid_o, 0);
    check("rst_busy", dump_busy_o, 0);
    check("rst_stall", cpu_stall_o, 0);
    check("rst_done", dump_done_o, 0);
    check("rst_addr", rd_addr_o, 0);
    check("rst_idx", out_idx_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_last", out_last_o, 0);
    rst = 0;

    // abandon a snapshot part-way through with an asynchronous reset
    @(posedge clk); #1;
    dump_req_i = 1; out_ready_i = 1;
    @(posedge clk); #1;
    dump_req_i = 0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (out_valid_o && out_idx_o == 15) found = 1;
    end
    check("reach_idx15", found, 1);
    rst = 1; #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_stall", cpu_stall_o, 0);
    check("mid_rst_busy", dump_busy_o, 0);
    check("mid_rst_idx", out_idx_o, 0);
    check("mid_rst_addr", rd_addr_o, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_done", dump_done_o, 0);
      check("post_rst_busy", dump_busy_o, 0);
    end

    vecs[0] = '{hold: 0,  rnd: 0, inj: 0, wr: 0, exp_done: 34};
    vecs[1] = '{hold: 10, rnd: 0, inj: 0, wr: 0, exp_done: 44};
    vecs[2] = '{hold: 1,  rnd: 0, inj: 1, wr: 1, exp_done: 35};
    vecs[3] = '{hold: 0,  rnd: 1, inj: 1, wr: 0, exp_done: -1};
    vecs[4] = '{hold: 0,  rnd: 1, inj: 0, wr: 0, exp_done: -1};
    for (int t = 0; t < 5; t++) run_dump(vecs[t]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
